// File: rtl/wptr_full_sync_ctrl_if.sv
// wptr_full_sync_ctrl_if: write-side request, read-pointer input and status bundle of the dual-clock FIFO
// master drives winc/rptr/ovf_clr and observes status; slave is the pointer controller
interface wptr_full_sync_ctrl_if #(parameter int ADDR_WIDTH = 4);
  logic winc;
  logic ovf_clr;
  logic wfull;
  logic walmost_full;
  logic wovf;
  logic [ADDR_WIDTH:0] rptr;
  logic [ADDR_WIDTH:0] wptr;
  logic [ADDR_WIDTH:0] wlevel;
  logic [ADDR_WIDTH-1:0] waddr;
  modport master(output winc, rptr, ovf_clr, input waddr, wptr, wfull, walmost_full, wlevel, wovf);
  modport slave(input winc, rptr, ovf_clr, output waddr, wptr, wfull, walmost_full, wlevel, wovf);
endinterface

// File: rtl/wptr_full_sync_ctrl.sv
// wptr_full_sync_ctrl: write-domain pointer, full/almost-full/level and overflow status for a dual-clock FIFO
// wclk, wrst_n (async active-low); bus.slave: winc, rptr (Gray, async), ovf_clr in;
// waddr, wptr (Gray), wfull, walmost_full, wlevel, wovf out
// WPTR_OVF_DETECT_EN builds the sticky overflow flag; otherwise wovf is tied low
module wptr_full_sync_ctrl #(
  parameter int ADDR_WIDTH   = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_MARGIN = 2
) (
  input  logic                 wclk,
  input  logic                 wrst_n,
  wptr_full_sync_ctrl_if.slave bus
);
  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH  = PW'(1) << ADDR_WIDTH;
  localparam logic [PW-1:0] MARGIN = PW'(AFULL_MARGIN);
  logic [PW-1:0] r_sync [SYNC_STAGES];
  logic [PW-1:0] r_wbin;
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_wlevel;
  logic          r_wfull;
  logic          r_walmost_full;
  logic [PW-1:0] w_rq;
  logic [PW-1:0] w_rbin;
  logic [PW-1:0] w_wbin_next;
  logic [PW-1:0] w_wgray_next;
  logic [PW-1:0] w_level_next;
  logic          w_accept;
  assign w_rq = r_sync[SYNC_STAGES-1];
  // Gray to binary: each bit is the XOR of all Gray bits at and above it
  for (genvar i = 0; i < PW; i++) begin : g_g2b
    assign w_rbin[i] = ^(w_rq >> i);
  end
  assign w_accept     = bus.winc & ~r_wfull;
  assign w_wbin_next  = r_wbin + PW'(w_accept);
  assign w_wgray_next = (w_wbin_next >> 1) ^ w_wbin_next;
  assign w_level_next = w_wbin_next - w_rbin;
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
      r_wbin         <= '0;
      r_wptr         <= '0;
      r_wlevel       <= '0;
      r_wfull        <= 1'b0;
      r_walmost_full <= 1'b0;
    end else begin
      r_sync[0] <= bus.rptr;
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
      r_wbin         <= w_wbin_next;
      r_wptr         <= w_wgray_next;
      // full when the write pointer is exactly one lap ahead: top two Gray bits inverted
      r_wfull        <= w_wgray_next == {~w_rq[PW-1:PW-2], w_rq[PW-3:0]};
      r_wlevel       <= w_level_next;
      r_walmost_full <= (DEPTH - w_level_next) <= MARGIN;
    end
  end
  assign bus.waddr        = r_wbin[ADDR_WIDTH-1:0];
  assign bus.wptr         = r_wptr;
  assign bus.wfull        = r_wfull;
  assign bus.walmost_full = r_walmost_full;
  assign bus.wlevel       = r_wlevel;
`ifdef WPTR_OVF_DETECT_EN
  logic r_wovf;
  // a new overflow outranks a simultaneous clear
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) r_wovf <= 1'b0;
    else r_wovf <= (bus.winc & r_wfull) | (r_wovf & ~bus.ovf_clr);
  end
  assign bus.wovf = r_wovf;
`else
  logic w_unused_ovf_clr;
  assign w_unused_ovf_clr = bus.ovf_clr;
  assign bus.wovf = 1'b0;
`endif
endmodule

// File: tb/tb_wptr_full_sync_ctrl.sv
// tb_wptr_full_sync_ctrl: table vectors, corner sequences and randomized run against a count-based model
module tb_wptr_full_sync_ctrl;
  localparam int AW     = 4;
  localparam int SYNC   = 2;
  localparam int MARGIN = 2;
  localparam int DEPTH  = 1 << AW;
  localparam int PMOD   = 2 * DEPTH;
`ifdef WPTR_OVF_DETECT_EN
  localparam int OVF_EN = 1;
`else
  localparam int OVF_EN = 0;
`endif
  typedef struct {
    logic winc;
    int   rc;
    logic oc;
    int   waddr;
    int   wptr;
    int   full;
    int   af;
    int   lvl;
    int   ovf;
  } vec_t;
  logic wclk = 1'b0;
  logic wrst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  int m_wcnt, m_lvl, m_full, m_af, m_ovf, cur_rc;
  int q[$];
  vec_t tbl[23];
  wptr_full_sync_ctrl_if #(.ADDR_WIDTH(AW)) bus();
  wptr_full_sync_ctrl #(.ADDR_WIDTH(AW), .SYNC_STAGES(SYNC), .AFULL_MARGIN(MARGIN)) dut (
    .wclk(wclk),
    .wrst_n(wrst_n),
    .bus(bus.slave)
  );
  always #5 wclk = ~wclk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  function automatic logic [4:0] gray(input int x);
    logic [4:0] b;
    b = x[4:0];
    return b ^ (b >> 1);
  endfunction
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endtask
  task automatic model_reset();
    m_wcnt = 0; m_lvl = 0; m_full = 0; m_af = 0; m_ovf = 0; cur_rc = 0;
    q.delete();
    for (int i = 0; i < SYNC; i++) q.push_back(0);
  endtask
  // occupancy = accepted writes minus the read count the write side has seen SYNC edges late
  task automatic model_edge();
    int rseen;
    int ovf_set;
    rseen = q.pop_front();
    q.push_back(cur_rc);
    ovf_set = (bus.winc === 1'b1 && m_full != 0) ? 1 : 0;
    if (bus.winc === 1'b1 && m_full == 0) m_wcnt++;
    m_lvl  = ((m_wcnt - rseen) % PMOD + PMOD) % PMOD;
    m_full = (m_lvl == DEPTH) ? 1 : 0;
    m_af   = (DEPTH - m_lvl <= MARGIN) ? 1 : 0;
    m_ovf  = (OVF_EN != 0 && (ovf_set != 0 || (m_ovf != 0 && bus.ovf_clr !== 1'b1))) ? 1 : 0;
  endtask
  task automatic cyc(input logic wi, input int rc, input logic oc);
    bus.winc = wi; bus.ovf_clr = oc; cur_rc = rc; bus.rptr = gray(rc);
    @(posedge wclk);
    model_edge();
    #1;
  endtask
  task automatic check_model(input string n);
    chk({n, ".waddr"}, 32'(bus.waddr), 32'(m_wcnt % DEPTH));
    chk({n, ".wptr"}, 32'(bus.wptr), 32'(gray(m_wcnt)));
    chk({n, ".wfull"}, 32'(bus.wfull), 32'(m_full));
    chk({n, ".afull"}, 32'(bus.walmost_full), 32'(m_af));
    chk({n, ".wlevel"}, 32'(bus.wlevel), 32'(m_lvl));
    chk({n, ".wovf"}, 32'(bus.wovf), 32'(m_ovf));
  endtask
  task automatic check_zero(input string n);
    chk({n, ".waddr"}, 32'(bus.waddr), 0);
    chk({n, ".wptr"}, 32'(bus.wptr), 0);
    chk({n, ".wfull"}, 32'(bus.wfull), 0);
    chk({n, ".afull"}, 32'(bus.walmost_full), 0);
    chk({n, ".wlevel"}, 32'(bus.wlevel), 0);
    chk({n, ".wovf"}, 32'(bus.wovf), 0);
  endtask
  task automatic do_reset();
    bus.winc = 1'b0; bus.ovf_clr = 1'b0; bus.rptr = '0;
    #2 wrst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.winc = i[0];
      @(posedge wclk);
      #1;
    end
    bus.winc = 1'b0;
    @(negedge wclk);
    wrst_n = 1'b1;
    model_reset();
  endtask
  initial begin
    int saw_addr_wrap, saw_ptr_wrap, any_full, pa, pp, rc;
    for (int i = 0; i < 16; i++)
      tbl[i] = '{1'b1, 0, 1'b0, (i + 1) % 16, int'(gray(i + 1)), (i == 15) ? 1 : 0, (i >= 13) ? 1 : 0, i + 1, 0};
    for (int i = 16; i < 19; i++)
      tbl[i] = '{1'b1, 0, (i == 18) ? 1'b1 : 1'b0, 0, 'h18, 1, 1, 16, OVF_EN};
    tbl[19] = '{1'b0, 4, 1'b0, 0, 'h18, 1, 1, 16, OVF_EN};
    tbl[20] = '{1'b0, 4, 1'b0, 0, 'h18, 1, 1, 16, OVF_EN};
    tbl[21] = '{1'b0, 4, 1'b0, 0, 'h18, 0, 0, 12, OVF_EN};
    tbl[22] = '{1'b0, 4, 1'b1, 0, 'h18, 0, 0, 12, 0};
    bus.winc = 1'b0; bus.ovf_clr = 1'b0; bus.rptr = '0;
    model_reset();
    #1;
    // reset with toggling winc holds everything at zero
    for (int i = 0; i < 4; i++) begin
      bus.winc = ~i[0];
      @(posedge wclk);
      #1;
      check_zero($sformatf("rst%0d", i));
    end
    bus.winc = 1'b0;
    @(negedge wclk);
    wrst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 0, 1'b0);
      check_zero($sformatf("idle%0d", i));
    end
    // fill, overflow, set-wins-over-clear, drain release, clear
    do_reset();
    foreach (tbl[i]) begin
      string n;
      n = $sformatf("tbl%0d", i);
      cyc(tbl[i].winc, tbl[i].rc, tbl[i].oc);
      chk({n, ".waddr"}, 32'(bus.waddr), tbl[i].waddr);
      chk({n, ".wptr"}, 32'(bus.wptr), tbl[i].wptr);
      chk({n, ".wfull"}, 32'(bus.wfull), tbl[i].full);
      chk({n, ".afull"}, 32'(bus.walmost_full), tbl[i].af);
      chk({n, ".wlevel"}, 32'(bus.wlevel), tbl[i].lvl);
      chk({n, ".wovf"}, 32'(bus.wovf), tbl[i].ovf);
    end
    // wrap: 40 writes with the reader trailing by 3
    do_reset();
    saw_addr_wrap = 0; saw_ptr_wrap = 0; any_full = 0;
    for (int i = 0; i < 40; i++) begin
      pa = int'(bus.waddr); pp = int'(bus.wptr);
      cyc(1'b1, (m_wcnt > 3) ? m_wcnt - 3 : 0, 1'b0);
      check_model($sformatf("wrap%0d", i));
      if (pa == 15 && bus.waddr == 0) saw_addr_wrap = 1;
      if (pp == 'h10 && bus.wptr == 0) saw_ptr_wrap = 1;
      if (bus.wfull) any_full = 1;
    end
    chk("wrap.addr_wrapped", 32'(saw_addr_wrap), 1);
    chk("wrap.ptr_wrapped", 32'(saw_ptr_wrap), 1);
    chk("wrap.never_full", 32'(any_full), 0);
    // asynchronous reset in the middle of a fill
    do_reset();
    for (int i = 0; i < 9; i++) cyc(1'b1, 0, 1'b0);
    chk("midrst.level9", 32'(bus.wlevel), 9);
    #2 wrst_n = 1'b0;
    #1 check_zero("midrst.async");
    model_reset();
    bus.winc = 1'b0;
    @(negedge wclk);
    wrst_n = 1'b1;
    chk("midrst.addr_before", 32'(bus.waddr), 0);
    cyc(1'b1, 0, 1'b0);
    check_model("midrst.first");
    // randomized traffic, reader speed alternating to reach full and empty often
    do_reset();
    rc = 0;
    for (int i = 0; i < 800; i++) begin
      if (rc < m_wcnt && $urandom_range(99) < (((i / 100) % 2 == 1) ? 20 : 80)) rc++;
      cyc(($urandom_range(99) < 70) ? 1'b1 : 1'b0, rc, ($urandom_range(99) < 10) ? 1'b1 : 1'b0);
      check_model($sformatf("rnd%0d", i));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wptr_full_sync_ctrl.md
# wptr_full_sync_ctrl

Write-domain pointer and status controller for the dual-clock FIFO, parametrised in depth and synchroniser length. It drives the write address and the Gray-coded write pointer toward the read domain. It synchronises the read domain's Gray pointer internally and produces registered full, almost-full, fill-level and sticky overflow status, all in the write clock domain.

## Interface
- ADDR_WIDTH, 4: address bits; depth = 2^ADDR_WIDTH; legal range ≥ 2.
- SYNC_STAGES, 2: flop stages on the incoming read pointer; legal range ≥ 2.
- AFULL_MARGIN, 2: walmost_full asserts when free entries ≤ this value; legal range 0..depth-1.

- wclk  in  1  write clock; all state is on the rising edge.
- wrst_n  in  1  asynchronous active-low reset; one clock; the reset polarity and synchronicity are fixed.
- winc  in  1  write request for the current cycle.
- rptr  in  ADDR_WIDTH+1  Gray read pointer, asynchronous to wclk.
- ovf_clr  in  1  clears wovf.
- waddr  out  ADDR_WIDTH  RAM write address, equal to wbin[ADDR_WIDTH-1:0].
- wptr  out  ADDR_WIDTH+1  registered Gray write pointer sent to the read domain.
- wfull  out  1  registered full flag.
- walmost_full  out  1  registered almost-full flag.
- wlevel  out  ADDR_WIDTH+1  registered occupancy, 0..depth.
- wovf  out  1  sticky overflow flag.

## Operation
- Synchroniser: rptr passes through SYNC_STAGES flops. The last stage is rq_ptr. No logic sits between stages.
- rbin_s is the Gray-to-binary conversion of rq_ptr (XOR prefix from the MSB). It is combinational.
- Accept condition: accept = winc & ~wfull.
- Next binary pointer: wbin_next = wbin + accept, modulo 2^(ADDR_WIDTH+1).
- Next Gray pointer: wgray_next = (wbin_next >> 1) ^ wbin_next.
- Registered on each edge: wbin ← wbin_next and wptr ← wgray_next.
- Full: wfull ← (wgray_next == {~rq_ptr[MSB:MSB-1], rq_ptr[MSB-2:0]}).
- Level: wlevel ← wbin_next − rbin_s, modulo 2^(ADDR_WIDTH+1). The value is conservative because the read pointer lags.
- Almost full: walmost_full ← ((depth − (wbin_next − rbin_s)) ≤ AFULL_MARGIN). With AFULL_MARGIN = 0 it equals wfull.
- Write when full: winc while wfull is a dropped write. wbin and wptr hold, and waddr is unchanged.
- Wrap-around: the binary pointer wraps from 2^(ADDR_WIDTH+1)−1 to 0, and the extra MSB distinguishes full from empty. No special case exists at the wrap.

## Timing
- Reset values: waddr, wptr, wlevel, wfull, walmost_full, wovf and all synchroniser flops are 0. Reset takes effect asynchronously, and release is synchronous to wclk.
- Reset mid-operation: all state clears immediately. Writes in flight are lost. The read domain sees wptr = 0.
- Accepted write on edge N: waddr, wptr, wlevel and the flags reflect it after edge N. Latency is 1 cycle with no bubble, so back-to-back writes are accepted every cycle until full.
- Read pointer change sampled at edge K: rq_ptr updates after edge K+SYNC_STAGES−1. The flags and wlevel update at edge K+SYNC_STAGES.
- A simultaneous write and read-pointer change are both applied in the same next-state computation.
- The write that fills the last slot asserts wfull on the same edge as its wptr update.

## Configuration
- Macro WPTR_OVF_DETECT_EN.
- Defined: wovf ← 1 on any edge where winc & wfull, and it holds until an edge with ovf_clr = 1 and no new overflow. If set and clear occur on the same edge, set wins.
- Undefined: wovf is constant 0, ovf_clr is ignored, and no overflow flop is built.
- Dropped-write behaviour is identical in both builds.

## Test plan
All scenarios use ADDR_WIDTH=4, SYNC_STAGES=2, AFULL_MARGIN=2.
- Reset: drive wrst_n=0 with toggling winc -> all outputs are 0. After release with winc=0, all outputs stay 0.
- Fill: hold rptr=0 and apply 16 consecutive winc.
  - waddr steps 0..15.
  - walmost_full rises after the 14th write.
  - wfull rises after the 16th write.
  - Final values: wlevel=16, wptr=0x18.
- Overflow (macro defined): from full, apply 3 more winc.
  - wptr stays 0x18 and wlevel stays 16.
  - wovf=1 and remains set.
  - Pulse ovf_clr -> wovf=0 on the next edge.
- Drain release: with the block full, set rptr=0x06 (Gray of 4) -> 2 edges later wfull=0, walmost_full=0, wlevel=12.
- Wrap: perform 40 writes while advancing rptr to track them within 3 entries.
  - waddr wraps 15→0.
  - wptr wraps 0x10→0x00.
  - wfull never asserts.
- Reset mid-fill: assert wrst_n at wlevel=9 -> outputs are 0 before the next wclk edge. The next accepted write drives waddr to 0.
